// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, ghost rejection and decimal entry.
// Ports:
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   row_in[3:0]    keypad rows, active low, asynchronous to clk
//   col_out[3:0]   column drive, one-cold
//   key_valid      one-cycle pulse per accepted key press
//   key_code[3:0]  code of the last accepted key
//   entered_number accumulated decimal entry, 0..9999
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entered_number
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    // Nibble (r*4+c) holds the code of the key at row r, column c.
    localparam logic [63:0] KEY_MAP = {4'd13, 4'd15, 4'd0, 4'd14,
                                       4'd12, 4'd9,  4'd8, 4'd7,
                                       4'd11, 4'd6,  4'd5, 4'd4,
                                       4'd10, 4'd3,  4'd2, 4'd1};

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state, state_nx;
    logic [3:0]      row_meta, row_sync;
    logic [DW-1:0]   div;
    logic [1:0]      col_idx;
    logic [15:0]     frame_map, map_nx;
    logic [3:0]      cand, cand_nx, key_idx, key;
    logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
    logic [4:0]      hits;
    logic            sample, frame_end, single, any, accept;
    logic [15:0]     number_nx;

    assign sample    = div == DW'(SCAN_DIV - 1);
    assign frame_end = sample && col_idx == 2'd3;
    assign cnt_inc   = cnt + 1'b1;

    // Merge the current column's rows into the map so frame_end classifies the complete frame.
    always_comb begin
        map_nx = frame_map;
        for (int r = 0; r < 4; r++)
            if (sample) map_nx[{2'(r), col_idx}] = ~row_sync[r];
        hits    = '0;
        key_idx = '0;
        for (int i = 0; i < 16; i++)
            if (map_nx[i]) begin
                hits    = hits + 5'd1;
                key_idx = 4'(i);
            end
        single = hits == 5'd1;
        any    = |map_nx;
        key    = KEY_MAP[{key_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            row_meta       <= 4'hF;
            row_sync       <= 4'hF;
            div            <= '0;
            col_idx        <= '0;
            frame_map      <= '0;
            state          <= IDLE;
            cand           <= '0;
            cnt            <= '0;
            key_valid      <= 1'b0;
            key_code       <= '0;
            entered_number <= '0;
        end else begin
            row_meta  <= row_in;
            row_sync  <= row_meta;
            div       <= sample ? '0 : div + 1'b1;
            col_idx   <= col_idx + {1'b0, sample};
            frame_map <= frame_end ? '0 : map_nx;
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            key_valid <= accept;
            if (accept) begin
                key_code       <= cand_nx;
                entered_number <= number_nx;
            end
        end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        accept   = 1'b0;
        if (frame_end)
            case (state)
                IDLE:
                    if (single) begin
                        cand_nx  = key;
                        cnt_nx   = CW'(1);
                        accept   = DEBOUNCE_SCANS == 1;
                        state_nx = DEBOUNCE_SCANS == 1 ? HELD : DEBOUNCE;
                    end
                DEBOUNCE:
                    if (!single) state_nx = IDLE;
                    else if (key != cand) begin
                        cand_nx = key;
                        cnt_nx  = CW'(1);
                    end else begin
                        cnt_nx   = cnt_inc;
                        accept   = cnt_inc == CW'(DEBOUNCE_SCANS);
                        state_nx = accept ? HELD : DEBOUNCE;
                    end
                HELD:
                    if (!any) begin
                        cnt_nx   = CW'(1);
                        state_nx = DEBOUNCE_SCANS == 1 ? IDLE : RELEASE;
                    end
                default:
                    if (any) state_nx = HELD;
                    else begin
                        cnt_nx   = cnt_inc;
                        state_nx = cnt_inc == CW'(DEBOUNCE_SCANS) ? IDLE : RELEASE;
                    end
            endcase
    end

    // Digits shift in from the right and drop the oldest; '#' backspaces, '*' clears, A-D leave it.
    always_comb begin
        col_out   = ~(4'b0001 << col_idx);
        number_nx = cand_nx <= 4'd9  ? (entered_number % 16'd1000) * 16'd10 + {12'd0, cand_nx} :
                    cand_nx == 4'd15 ? entered_number / 16'd10 :
                    cand_nx == 4'd14 ? 16'd0 : entered_number;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with a keypad model.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entered_number;
    logic [15:0] keys = '0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_in(row_in),
        .col_out(col_out),
        .key_valid(key_valid),
        .key_code(key_code),
        .entered_number(entered_number)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);

    always @(negedge clk)
        if (key_valid === 1'b1) pulses <= pulses + 1;

    task automatic wait_frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] k, input int on_f, input int off_f);
        keys = k;
        wait_frames(on_f);
        keys = '0;
        wait_frames(off_f);
    endtask

    task automatic test_reset;
        logic [3:0] exp;
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col_out); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
        if (entered_number !== 16'd0) begin errors++; $display("FAIL reset_num: got %0d want 0", entered_number); end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = ~(4'b0001 << (i / 4));
            checks++;
            if (col_out !== exp) begin errors++; $display("FAIL scan_col[%0d]: got %b want %b", i, col_out, exp); end
            @(negedge clk);
        end
        wait_frames(1);
        checks += 3;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b want 1110", col_out); end
        if (pulses !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
        if (entered_number !== 16'd0) begin errors++; $display("FAIL idle_num: got %0d want 0", entered_number); end
    endtask

    task automatic test_single_press;
        int p0;
        p0 = pulses;
        keys = 16'h0020;
        repeat (31) @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL early_kv: got %b want 0", key_valid); end
        @(negedge clk);
        checks += 2;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL latency_kv: got %b want 1", key_valid); end
        if (key_code !== 4'd5) begin errors++; $display("FAIL code_5: got %0d want 5", key_code); end
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", key_valid); end
        repeat (96 - 33) @(negedge clk);
        keys = '0;
        wait_frames(3);
        checks += 2;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL held_pulses: got %0d want 1", pulses - p0); end
        if (entered_number !== 16'd5) begin errors++; $display("FAIL num_5: got %0d want 5", entered_number); end
    endtask

    task automatic test_digit_entry;
        logic [15:0] k_tab [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0010, 16'h0020};
        logic [15:0] n_tab [5] = '{16'd1, 16'd12, 16'd123, 16'd1234, 16'd2345};
        int p0;
        press(16'h1000, 3, 3);
        checks++;
        if (entered_number !== 16'd0) begin errors++; $display("FAIL clear_pre: got %0d want 0", entered_number); end
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            press(k_tab[i], 3, 3);
            checks++;
            if (entered_number !== n_tab[i]) begin errors++; $display("FAIL entry[%0d]: got %0d want %0d", i, entered_number, n_tab[i]); end
        end
        checks++;
        if (pulses - p0 !== 5) begin errors++; $display("FAIL entry_pulses: got %0d want 5", pulses - p0); end
    endtask

    task automatic test_special_keys;
        press(16'h4000, 3, 3);
        checks += 2;
        if (key_code !== 4'd15) begin errors++; $display("FAIL code_hash: got %0d want 15", key_code); end
        if (entered_number !== 16'd234) begin errors++; $display("FAIL backspace: got %0d want 234", entered_number); end
        press(16'h0008, 3, 3);
        checks += 2;
        if (key_code !== 4'd10) begin errors++; $display("FAIL code_A: got %0d want 10", key_code); end
        if (entered_number !== 16'd234) begin errors++; $display("FAIL letter_keep: got %0d want 234", entered_number); end
        press(16'h1000, 3, 3);
        checks += 2;
        if (key_code !== 4'd14) begin errors++; $display("FAIL code_star: got %0d want 14", key_code); end
        if (entered_number !== 16'd0) begin errors++; $display("FAIL clear: got %0d want 0", entered_number); end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 2; i++) begin
            keys = 16'h0100;
            wait_frames(1);
            keys = '0;
            wait_frames(1);
        end
        keys = 16'h0100;
        wait_frames(1);
        checks++;
        if (pulses - p0 !== 0) begin errors++; $display("FAIL bounce_early: got %0d want 0", pulses - p0); end
        wait_frames(2);
        checks += 3;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL bounce_pulse: got %0d want 1", pulses - p0); end
        if (key_code !== 4'd7) begin errors++; $display("FAIL code_7: got %0d want 7", key_code); end
        if (entered_number !== 16'd7) begin errors++; $display("FAIL num_7: got %0d want 7", entered_number); end
        keys = '0;
        wait_frames(1);
        keys = 16'h0100;
        wait_frames(3);
        keys = '0;
        wait_frames(3);
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL dropout_pulse: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_multi_key;
        int p0;
        p0 = pulses;
        press(16'h0401, 5, 3);
        checks += 2;
        if (pulses - p0 !== 0) begin errors++; $display("FAIL multi_pulse: got %0d want 0", pulses - p0); end
        if (entered_number !== 16'd7) begin errors++; $display("FAIL multi_num: got %0d want 7", entered_number); end
    endtask

    task automatic test_reset_mid;
        int p0;
        keys = 16'h0004;
        wait_frames(1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b want 1110", col_out); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_kv: got %b want 0", key_valid); end
        if (key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d want 0", key_code); end
        if (entered_number !== 16'd0) begin errors++; $display("FAIL midrst_num: got %0d want 0", entered_number); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (31) @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL postrst_early: got %b want 0", key_valid); end
        @(negedge clk);
        checks += 2;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL postrst_kv: got %b want 1", key_valid); end
        if (key_code !== 4'd3) begin errors++; $display("FAIL postrst_code: got %0d want 3", key_code); end
        repeat (16) @(negedge clk);
        keys = '0;
        wait_frames(3);
        checks += 2;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL postrst_pulses: got %0d want 1", pulses - p0); end
        if (entered_number !== 16'd3) begin errors++; $display("FAIL postrst_num: got %0d want 3", entered_number); end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_digit_entry;
        test_special_keys;
        test_bounce;
        test_multi_key;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
